// File: rtl/increment_scheduler_pkg.sv
// increment_scheduler_pkg
//   Shared types and default cycle constants for the set-up increment path.
//   - state_t : scheduler FSM encoding (IDLE / HOLD / REPEAT)
//   - owner_t : which button currently owns the increment path
//   - DEF_*   : default timing constants for a 100 MHz clock. The debouncer
//               and the minutes/seconds counter use the same constants.
package increment_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_SEC = 1'b0,
    OWN_MIN = 1'b1
  } owner_t;

  localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;  // 100 ms
  localparam int unsigned DEF_ACCEL_AFTER   = 8;

endpackage

// File: rtl/increment_scheduler_if.sv
// increment_scheduler_if
//   Groups the button requests and the increment pulses between the debouncer
//   side (master) and the increment scheduler (slave).
//   Signals:
//     arm      master->slave  1 = timer in set-up mode
//     sec_req  master->slave  debounced seconds button level
//     min_req  master->slave  debounced minutes button level
//     inc_sec  slave->master  1-cycle pulse: add one second
//     inc_min  slave->master  1-cycle pulse: add one minute
//     busy     slave->master  1 while a requester owns the increment path
interface increment_scheduler_if;
  logic arm;
  logic sec_req;
  logic min_req;
  logic inc_sec;
  logic inc_min;
  logic busy;

  modport master (
    output arm, sec_req, min_req,
    input  inc_sec, inc_min, busy
  );

  modport slave (
    input  arm, sec_req, min_req,
    output inc_sec, inc_min, busy
  );
endinterface

// File: rtl/increment_scheduler_rise_detect.sv
// increment_scheduler_rise_detect
//   1-bit rising-edge detector. The history register resets to 1, so a
//   request that is already high when reset ends never produces an edge.
//   The history updates every cycle regardless of arm.
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous, active-high reset
//     req    in   request level
//     rise   out  combinational: req high now, low last cycle
module increment_scheduler_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= req;
  end

  assign rise = req & ~prev_q;

endmodule

// File: rtl/increment_scheduler.sv
// increment_scheduler
//   Shares the counter's single-step set-up path between the debounced
//   seconds and minutes buttons. A rising edge while armed gives one
//   registered increment pulse. Holding the button gives a further pulse
//   after HOLD_CYCLES and then one every REPEAT_CYCLES. Minutes wins a
//   same-cycle rise. The owner keeps the path until its own request drops.
//   Optional feature macro: INC_ACCEL_EN. When defined, the repeat period
//   shrinks to REPEAT_CYCLES/4 after ACCEL_AFTER repeat pulses.
//   Ports:
//     clk    in   system clock (100 MHz)
//     reset  in   synchronous, active-high reset
//     bus    slave modport of increment_scheduler_if
//            (arm, sec_req, min_req in; inc_sec, inc_min, busy out)
module increment_scheduler
  import increment_scheduler_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,    // must be >= REPEAT_CYCLES
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES   // must be >= 4
`ifdef INC_ACCEL_EN
  ,
  parameter int unsigned ACCEL_AFTER   = DEF_ACCEL_AFTER
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  increment_scheduler_if.slave  bus
);

  localparam int TW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX = '1;

  logic rise_sec;
  logic rise_min;

  increment_scheduler_rise_detect u_rise_sec (
    .clk   (clk),
    .reset (reset),
    .req   (bus.sec_req),
    .rise  (rise_sec)
  );

  increment_scheduler_rise_detect u_rise_min (
    .clk   (clk),
    .reset (reset),
    .req   (bus.min_req),
    .rise  (rise_min)
  );

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            inc_sec_q, inc_sec_d;
  logic            inc_min_q, inc_min_d;
  logic            owner_req;
  logic [TW-1:0]   timer_next;
  logic [TW-1:0]   period_last;

`ifdef INC_ACCEL_EN
  localparam int RCW = $clog2(ACCEL_AFTER + 1);
  localparam logic [TW-1:0]  FAST_LAST = TW'(REPEAT_CYCLES / 4 - 1);
  localparam logic [RCW-1:0] REP_SAT   = RCW'(ACCEL_AFTER);

  logic [RCW-1:0] rep_cnt_q, rep_cnt_d;

  assign period_last = (rep_cnt_q == REP_SAT) ? FAST_LAST : REP_LAST;
`else
  assign period_last = REP_LAST;
`endif

  assign owner_req  = (owner_q == OWN_MIN) ? bus.min_req : bus.sec_req;
  // The timer saturates instead of wrapping.
  assign timer_next = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

  // ---- next-state / pulse decode ----
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    inc_sec_d = 1'b0;
    inc_min_d = 1'b0;
`ifdef INC_ACCEL_EN
    rep_cnt_d = rep_cnt_q;
`endif

    if (!bus.arm) begin
      state_d = ST_IDLE;
      timer_d = '0;
`ifdef INC_ACCEL_EN
      rep_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          if (rise_min) begin
            owner_d   = OWN_MIN;
            inc_min_d = 1'b1;
            state_d   = ST_HOLD;
          end else if (rise_sec) begin
            owner_d   = OWN_SEC;
            inc_sec_d = 1'b1;
            state_d   = ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (!owner_req) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == HOLD_LAST) begin
            inc_min_d = (owner_q == OWN_MIN);
            inc_sec_d = (owner_q == OWN_SEC);
            timer_d   = '0;
            state_d   = ST_REPEAT;
          end else begin
            timer_d = timer_next;
          end
        end

        ST_REPEAT: begin
          if (!owner_req) begin
            state_d = ST_IDLE;
            timer_d = '0;
`ifdef INC_ACCEL_EN
            rep_cnt_d = '0;
`endif
          end else if (timer_q == period_last) begin
            inc_min_d = (owner_q == OWN_MIN);
            inc_sec_d = (owner_q == OWN_SEC);
            timer_d   = '0;
`ifdef INC_ACCEL_EN
            // Only pulses issued from REPEAT count toward acceleration.
            rep_cnt_d = (rep_cnt_q == REP_SAT) ? rep_cnt_q : rep_cnt_q + RCW'(1);
`endif
          end else begin
            timer_d = timer_next;
          end
        end

        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_SEC;
      timer_q   <= '0;
      inc_sec_q <= 1'b0;
      inc_min_q <= 1'b0;
`ifdef INC_ACCEL_EN
      rep_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      inc_sec_q <= inc_sec_d;
      inc_min_q <= inc_min_d;
`ifdef INC_ACCEL_EN
      rep_cnt_q <= rep_cnt_d;
`endif
    end
  end

  // Dropping arm kills a pulse already in flight in the same cycle.
  assign bus.inc_sec = inc_sec_q & bus.arm;
  assign bus.inc_min = inc_min_q & bus.arm;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule
